// File: rtl/bank_to_register_collector_pkg.sv
// Shared dispatcher definitions: register/bank geometry, per-tid bank
// offset and the collector state encoding.
package bank_to_register_collector_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;

   localparam logic [REG_IDX_W-1:0] BANK_OFF_0 = 5'd0;
   localparam logic [REG_IDX_W-1:0] BANK_OFF_1 = 5'd16;
   localparam logic [REG_IDX_W-1:0] BANK_OFF_2 = 5'd8;
   localparam logic [REG_IDX_W-1:0] BANK_OFF_3 = 5'd24;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      COLLECT,
      DONE
   } coll_state_e;

   function automatic logic [REG_IDX_W-1:0] tid_bank_offset(
      input logic [REG_IDX_W-1:0] tid
   );
      logic [REG_IDX_W-1:0] off;
      unique case (tid[4:3])
         2'd0:    off = BANK_OFF_0;
         2'd1:    off = BANK_OFF_1;
         2'd2:    off = BANK_OFF_2;
         default: off = BANK_OFF_3;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/bank_to_register_collector_unmapper.sv
// Inverse swizzle: bank bitmap -> register bitmap, plus the register
// index owned by every bank for the given thread.
module bank_to_register_unmapper
   import bank_to_register_collector_pkg::*;
(
   input  logic [REG_IDX_W-1:0]                tid_i,
   input  logic [NUM_REGS-1:0]                 bank_bitmap_i,
   output logic [NUM_REGS-1:0]                 reg_bitmap_o,
   output logic [NUM_REGS-1:0][REG_IDX_W-1:0]  reg_idx_o
);

   logic [REG_IDX_W-1:0] off;

   assign off = tid_bank_offset(tid_i);

   always_comb begin
      reg_bitmap_o = '0;
      reg_idx_o    = '0;
      for (int b = 0; b < NUM_REGS; b++) begin
         reg_idx_o[b] = REG_IDX_W'(b) - tid_i - off;
         reg_bitmap_o[reg_idx_o[b]] = bank_bitmap_i[b];
      end
   end

endmodule

// File: rtl/register_to_bank_mapper.sv
// Forward swizzle: register bitmap of a thread -> bank bitmap.
// Bank of register r is (tid + r + offset) mod 32.
module register_to_bank_mapper
   import bank_to_register_collector_pkg::*;
(
   input  logic [REG_IDX_W-1:0] tid_i,
   input  logic [NUM_REGS-1:0]  reg_bitmap_i,
   output logic [NUM_REGS-1:0]  bank_bitmap_o
);

   logic [REG_IDX_W-1:0] off;

   assign off = tid_bank_offset(tid_i);

   always_comb begin
      bank_bitmap_o = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         bank_bitmap_o[tid_i + REG_IDX_W'(r) + off] = reg_bitmap_i[r];
      end
   end

endmodule

// File: rtl/bank_to_register_collector.sv
// Operand-read collector: issues a swizzled bank read, gathers bank
// responses and returns them un-swizzled as a register vector.
module bank_to_register_collector
   import bank_to_register_collector_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [REG_IDX_W-1:0]         req_tid,
   input  logic [NUM_REGS-1:0]          req_reg_bitmap,
   output logic                         bank_req_valid,
   input  logic                         bank_req_ready,
   output logic [NUM_REGS-1:0]          bank_req_bitmap,
   input  logic [NUM_REGS-1:0]          bank_rsp_valid,
   input  logic [NUM_REGS*DATA_W-1:0]   bank_rsp_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [REG_IDX_W-1:0]         out_tid,
   output logic [NUM_REGS-1:0]          out_reg_bitmap,
   output logic [NUM_REGS*DATA_W-1:0]   out_reg_data,
   output logic                         rsp_unexpected
);

   coll_state_e                        state_q;
   logic [NUM_REGS-1:0]                pending_q;
   logic [NUM_REGS-1:0]                map_bitmap;
   logic [NUM_REGS-1:0]                cap;
   logic [NUM_REGS-1:0]                slot_hit;
   logic [NUM_REGS-1:0][REG_IDX_W-1:0] slot_idx;
   logic [NUM_REGS-1:0]                pending_d;

   register_to_bank_mapper u_map (
      .tid_i        (req_tid),
      .reg_bitmap_i (req_reg_bitmap),
      .bank_bitmap_o(map_bitmap)
   );

   bank_to_register_unmapper u_unmap (
      .tid_i        (out_tid),
      .bank_bitmap_i(cap),
      .reg_bitmap_o (slot_hit),
      .reg_idx_o    (slot_idx)
   );

   // Only pending banks in COLLECT are captured; anything else is stray.
   assign cap = (state_q == COLLECT) ? (bank_rsp_valid & pending_q) : '0;
   assign pending_d = pending_q & ~cap;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         req_ready       <= 1'b1;
         bank_req_valid  <= 1'b0;
         bank_req_bitmap <= '0;
         pending_q       <= '0;
         out_valid       <= 1'b0;
         out_tid         <= '0;
         out_reg_bitmap  <= '0;
         out_reg_data    <= '0;
         rsp_unexpected  <= 1'b0;
      end else begin
         if (|(bank_rsp_valid & ~cap)) rsp_unexpected <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_ready       <= 1'b0;
                  out_tid         <= req_tid;
                  out_reg_bitmap  <= req_reg_bitmap;
                  bank_req_bitmap <= map_bitmap;
                  pending_q       <= map_bitmap;
                  out_reg_data    <= '0;
                  if (req_reg_bitmap == '0) begin
                     state_q   <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state_q        <= ISSUE;
                     bank_req_valid <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (bank_req_ready) begin
                  bank_req_valid <= 1'b0;
                  state_q        <= COLLECT;
               end
            end
            COLLECT: begin
               for (int b = 0; b < NUM_REGS; b++) begin
                  if (slot_hit[slot_idx[b]] && cap[b])
                     out_reg_data[int'(slot_idx[b])*DATA_W +: DATA_W]
                        <= bank_rsp_data[b*DATA_W +: DATA_W];
               end
               pending_q <= pending_d;
               if (pending_d == '0) begin
                  state_q   <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bank_to_register_collector.sv
// Directed bench for bank_to_register_collector: hand-computed swizzle
// vectors, multi-cycle collection, back-pressure, empty request, reset.
module tb_bank_to_register_collector;

   localparam int DW = 32;
   localparam int NB = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic [4:0]       req_tid;
   logic [NB-1:0]    req_reg_bitmap;
   logic             bank_req_valid;
   logic             bank_req_ready;
   logic [NB-1:0]    bank_req_bitmap;
   logic [NB-1:0]    bank_rsp_valid;
   logic [NB*DW-1:0] bank_rsp_data;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       out_tid;
   logic [NB-1:0]    out_reg_bitmap;
   logic [NB*DW-1:0] out_reg_data;
   logic             rsp_unexpected;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bank_to_register_collector #(.DATA_W(DW)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_tid        (req_tid),
      .req_reg_bitmap (req_reg_bitmap),
      .bank_req_valid (bank_req_valid),
      .bank_req_ready (bank_req_ready),
      .bank_req_bitmap(bank_req_bitmap),
      .bank_rsp_valid (bank_rsp_valid),
      .bank_rsp_data  (bank_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_tid        (out_tid),
      .out_reg_bitmap (out_reg_bitmap),
      .out_reg_data   (out_reg_data),
      .rsp_unexpected (rsp_unexpected)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] slot(input int r);
      return out_reg_data[r*DW +: DW];
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic put(input int b, input logic [31:0] d);
      bank_rsp_data[b*DW +: DW] = d;
   endtask

   // request accepted, bank bitmap checked, bank request accepted
   task automatic issue(input logic [4:0] tid, input logic [31:0] bm,
                        input logic [31:0] exp_banks);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_tid = tid;
      req_reg_bitmap = bm;
      step();
      req_valid = 1'b0;
      chk("bank_req_valid", 32'(bank_req_valid), 32'd1);
      chk("bank_req_bitmap", bank_req_bitmap, exp_banks);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      bank_req_ready = 1'b1;
      step();
      bank_req_ready = 1'b0;
      chk("bank_req_drop", 32'(bank_req_valid), 32'd0);
   endtask

   task automatic rsp(input logic [31:0] mask);
      bank_rsp_valid = mask;
      step();
      bank_rsp_valid = '0;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("out_valid_clr", 32'(out_valid), 32'd0);
      chk("req_ready_back", 32'(req_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0;
      req_tid = '0;
      req_reg_bitmap = '0;
      bank_req_ready = 1'b0;
      bank_rsp_valid = '0;
      bank_rsp_data = '0;
      out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_bank_valid", 32'(bank_req_valid), 32'd0);
      chk("rst_bank_bm", bank_req_bitmap, 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_bm", out_reg_bitmap, 32'd0);
      chk("rst_unexp", 32'(rsp_unexpected), 32'd0);

      // tid 9, r3: 9+3+16 = bank 28
      issue(5'd9, 32'h8, 32'h1000_0000);
      put(28, 32'hDEAD_BEEF);
      rsp(32'h1000_0000);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_tid", 32'(out_tid), 32'd9);
      chk("t1_bm", out_reg_bitmap, 32'h8);
      chk("t1_slot3", slot(3), 32'hDEAD_BEEF);
      chk("t1_slot28", slot(28), 32'd0);
      accept();

      // tid 30, r5: 30+5+24 = 59 -> bank 27
      issue(5'd30, 32'h20, 32'h0800_0000);
      put(27, 32'h1234_5678);
      rsp(32'h0800_0000);
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      chk("t2_slot5", slot(5), 32'h1234_5678);
      chk("t2_slot3", slot(3), 32'd0);
      chk("t2_slot27", slot(27), 32'd0);
      accept();

      // tid 0, all registers, all banks in one cycle
      issue(5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int b = 0; b < NB; b++) put(b, 32'hA500_0000 | 32'(b));
      rsp(32'hFFFF_FFFF);
      chk("t3_out_valid", 32'(out_valid), 32'd1);
      for (int r = 0; r < NB; r++)
         chk($sformatf("t3_slot%0d", r), slot(r), 32'hA500_0000 | 32'(r));
      accept();

      // tid 17 (off 8), r1->26, r4->29, r10->3
      issue(5'd17, 32'h0000_0412, 32'h2400_0008);
      put(3, 32'h1111_0003);
      put(29, 32'h2222_001D);
      put(26, 32'h3333_001A);
      rsp(32'h0000_0008);
      chk("t4_wait1", 32'(out_valid), 32'd0);
      rsp(32'h2000_0000);
      chk("t4_wait2", 32'(out_valid), 32'd0);
      rsp(32'h0400_0000);
      req_valid = 1'b1;
      req_tid = 5'd2;
      req_reg_bitmap = 32'h1;
      for (int i = 0; i < 4; i++) begin
         chk("t4_hold_valid", 32'(out_valid), 32'd1);
         chk("t4_hold_ready", 32'(req_ready), 32'd0);
         chk("t4_tid", 32'(out_tid), 32'd17);
         chk("t4_slot10", slot(10), 32'h1111_0003);
         chk("t4_slot4", slot(4), 32'h2222_001D);
         chk("t4_slot1", slot(1), 32'h3333_001A);
         if (i == 1) begin
            put(3, 32'hBAD0_BAD0);
            bank_rsp_valid = 32'h8;
         end
         step();
         bank_rsp_valid = '0;
      end
      req_valid = 1'b0;
      chk("t4_dup_flag", 32'(rsp_unexpected), 32'd1);
      chk("t4_dup_slot10", slot(10), 32'h1111_0003);
      accept();

      // empty bitmap: DONE directly, no bank request
      req_valid = 1'b1;
      req_tid = 5'd3;
      req_reg_bitmap = '0;
      step();
      req_valid = 1'b0;
      chk("t5_out_valid", 32'(out_valid), 32'd1);
      chk("t5_no_bank", 32'(bank_req_valid), 32'd0);
      chk("t5_zero", 32'(|out_reg_data), 32'd0);
      accept();

      // reset in COLLECT, then late response for bank 28
      put(28, 32'hFEED_F00D);
      issue(5'd9, 32'h8, 32'h1000_0000);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_req_ready", 32'(req_ready), 32'd1);
      chk("t6_bank_bm", bank_req_bitmap, 32'd0);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_unexp_clr", 32'(rsp_unexpected), 32'd0);
      rsp(32'h1000_0000);
      chk("t6_unexp_set", 32'(rsp_unexpected), 32'd1);
      chk("t6_slot3", slot(3), 32'd0);
      chk("t6_out_valid2", 32'(out_valid), 32'd0);
      chk("t6_idle", 32'(req_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
